// File: rtl/harmonic_chord_player.sv
// harmonic_chord_player: 3-voice chord synthesizer.
//   Notes (pitch + beat duration) are loaded into free voice slots and played
//   together while play_enable & activate. Each voice is a sine fundamental plus
//   up to three weighted harmonics; the three voices sum into an 18-bit sample.
// Ports:
//   clk, reset (sync, active low)
//   play_enable, activate         run = both high; otherwise countdown/phases freeze
//   note_to_load[5:0], duration[5:0], load_new_note   slot loading (dur 0 ignored)
//   beat                          1-cycle beat pulse, decrements remaining beats
//   generate_next_sample          sample request, answered one cycle later
//   weight[1:0]                   harmonic richness
//   final_sample[17:0]            signed chord sample
//   note_done                     pulse after the last sounding slot expired
//   sample_ready                  pulse: final_sample valid

// One voice: fundamental + harmonics 2..4 looked up from a quarter-wave table.
module harmonic_chord_voice (
  input  logic               active,
  input  logic [21:0]        phase,
  input  logic [1:0]         weight,
  output logic signed [15:0] voice
);
  function automatic logic [255:0][15:0] gen_qsin();
    logic [255:0][15:0] t;
    for (int i = 0; i < 256; i++)
      t[i] = 16'($rtoi(32767.0 * $sin(3.14159265358979 * i / 512.0) + 0.5));
    return t;
  endfunction

  localparam logic [255:0][15:0] QSIN = gen_qsin();

  // Odd quadrants walk the table backwards, upper half-cycle is negated.
  function automatic logic signed [15:0] sine(input logic [21:0] p);
    logic [7:0]         idx;
    logic signed [15:0] mag;
    idx  = p[20] ? ~p[19:12] : p[19:12];
    mag  = $signed(QSIN[idx]);
    sine = p[21] ? -mag : mag;
  endfunction

  logic [21:0]        p2, p3, p4;
  logic signed [17:0] s1, s2, s3, s4, acc;

  always_comb begin
    // Harmonic phases wrap naturally at 22 bits.
    p2  = {phase[20:0], 1'b0};
    p3  = phase + p2;
    p4  = {phase[19:0], 2'b00};
    s1  = 18'(sine(phase));
    s2  = 18'(sine(p2));
    s3  = 18'(sine(p3));
    s4  = 18'(sine(p4));
    acc = s1 >>> 1;
    if (weight != 2'd0) acc = acc + (s2 >>> 2);
    if (weight >= 2'd2) acc = acc + (s3 >>> 3);
    if (weight == 2'd3) acc = acc + (s4 >>> 4);
    voice = active ? acc[15:0] : 16'sd0;
  end
endmodule

module harmonic_chord_player (
  input  logic        clk,
  input  logic        reset,
  input  logic        play_enable,
  input  logic [5:0]  note_to_load,
  input  logic [5:0]  duration,
  input  logic        load_new_note,
  input  logic        activate,
  input  logic        beat,
  input  logic        generate_next_sample,
  input  logic [1:0]  weight,
  output logic [17:0] final_sample,
  output logic        note_done,
  output logic        sample_ready
);
  localparam int NUM_VOICES = 3;

  // Phase increment per 48 kHz sample; note 49 = A440.
  function automatic logic [63:0][21:0] gen_step();
    logic [63:0][21:0] t;
    t[0] = '0;
    for (int n = 1; n < 64; n++)
      t[n] = 22'($rtoi(4194304.0 * 440.0 * $pow(2.0, (n - 49) / 12.0) / 48000.0 + 0.5));
    return t;
  endfunction

  localparam logic [63:0][21:0] STEP = gen_step();

  logic [NUM_VOICES-1:0]             valid_q, valid_d;
  logic [NUM_VOICES-1:0][5:0]        note_q, note_d, rem_q, rem_d;
  logic [NUM_VOICES-1:0][21:0]       phase_q, phase_d;
  logic [NUM_VOICES-1:0][15:0]       voice;
  logic [17:0]                       sample_q, sample_d;
  logic                              done_q, done_d, ready_q, ready_d;
  logic                              run, tick, adv, load_ok, placed;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    harmonic_chord_voice u_voice (
      .active (valid_q[v] && (note_q[v] != 6'd0)),
      .phase  (phase_q[v]),
      .weight (weight),
      .voice  (voice[v])
    );
  end

  always_comb begin
    valid_d  = valid_q;
    note_d   = note_q;
    rem_d    = rem_q;
    phase_d  = phase_q;
    placed   = 1'b0;
    run      = play_enable & activate;
    tick     = beat & run;
    adv      = generate_next_sample & run;
    load_ok  = load_new_note & (duration != 6'd0);

    for (int v = 0; v < NUM_VOICES; v++) begin
      if (valid_q[v]) begin
        if (tick) begin
          rem_d[v] = rem_q[v] - 6'd1;
          if (rem_q[v] == 6'd1) valid_d[v] = 1'b0;
        end
        if (adv) phase_d[v] = phase_q[v] + STEP[note_q[v]];
      end
    end

    // Lowest free slot as of this cycle; a slot expiring now is not yet free.
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (load_ok && !placed && !valid_q[v]) begin
        placed     = 1'b1;
        valid_d[v] = 1'b1;
        note_d[v]  = note_to_load;
        rem_d[v]   = duration;
        phase_d[v] = '0;
      end
    end

    done_d   = tick & (|valid_q) & ~(|valid_d);
    ready_d  = generate_next_sample;
    sample_d = adv ? 18'($signed(voice[0])) + 18'($signed(voice[1])) + 18'($signed(voice[2]))
                   : 18'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q  <= '0;
      note_q   <= '0;
      rem_q    <= '0;
      phase_q  <= '0;
      sample_q <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      note_q   <= note_d;
      rem_q    <= rem_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign final_sample = sample_q;
  assign note_done    = done_q;
  assign sample_ready = ready_q;
endmodule

// File: tb/tb_harmonic_chord_player.sv
// Randomized + directed bench for harmonic_chord_player against a behavioural
// slot/sample model built from plain arithmetic and real-valued sine/pow.
module tb_harmonic_chord_player;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        play_enable = 1'b0, activate = 1'b0, load_new_note = 1'b0;
  logic        beat = 1'b0, generate_next_sample = 1'b0;
  logic [5:0]  note_to_load = '0, duration = '0;
  logic [1:0]  weight = '0;
  logic [17:0] final_sample;
  logic        note_done, sample_ready;

  harmonic_chord_player dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .note_to_load(note_to_load),
    .duration(duration), .load_new_note(load_new_note), .activate(activate), .beat(beat),
    .generate_next_sample(generate_next_sample), .weight(weight),
    .final_sample(final_sample), .note_done(note_done), .sample_ready(sample_ready)
  );

  always #5 clk = ~clk;

  localparam longint PM = 64'd4194304;
  localparam real    PI = 3.14159265358979;

  int     n_chk = 0, n_err = 0;
  int     m_valid[3], m_note[3], m_rem[3];
  longint m_phase[3];
  longint m_sample;
  int     m_done, m_ready;
  int     done_cnt, done_at, cyc, nz, peak;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int msin(input longint p);
    int q, i, idx, m;
    q   = int'((p >> 20) & 3);
    i   = int'((p >> 12) & 255);
    idx = (q % 2 == 1) ? 255 - i : i;
    m   = $rtoi(32767.0 * $sin(PI / 2.0 * idx / 256.0) + 0.5);
    return (q >= 2) ? -m : m;
  endfunction

  function automatic longint mstep(input int n);
    if (n == 0) return 0;
    return longint'($rtoi(4194304.0 * 440.0 * (2.0 ** ((n - 49) / 12.0)) / 48000.0 + 0.5));
  endfunction

  function automatic int mvoice(input longint p, input int w);
    int v;
    v = msin(p) >>> 1;
    if (w >= 1) v += msin((2 * p) % PM) >>> 2;
    if (w >= 2) v += msin((3 * p) % PM) >>> 3;
    if (w == 3) v += msin((4 * p) % PM) >>> 4;
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model();
    int run, any_before, any_after, placed, pre_valid[3];
    if (!reset) begin
      for (int v = 0; v < 3; v++) begin
        m_valid[v] = 0; m_note[v] = 0; m_rem[v] = 0; m_phase[v] = 0;
      end
      m_sample = 0; m_done = 0; m_ready = 0;
      return;
    end
    run = play_enable && activate;
    m_ready = generate_next_sample;
    m_sample = 0;
    any_before = 0;
    for (int v = 0; v < 3; v++) begin
      pre_valid[v] = m_valid[v];
      if (m_valid[v]) any_before = 1;
    end
    if (generate_next_sample && run) begin
      for (int v = 0; v < 3; v++)
        if (m_valid[v] && m_note[v] != 0) m_sample += mvoice(m_phase[v], int'(weight));
      for (int v = 0; v < 3; v++)
        if (m_valid[v]) m_phase[v] = (m_phase[v] + mstep(m_note[v])) % PM;
    end
    if (beat && run)
      for (int v = 0; v < 3; v++)
        if (m_valid[v]) begin
          m_rem[v]--;
          if (m_rem[v] == 0) m_valid[v] = 0;
        end
    if (load_new_note && duration != 0) begin
      placed = 0;
      for (int v = 0; v < 3; v++)
        if (!placed && !pre_valid[v]) begin
          placed = 1; m_valid[v] = 1; m_note[v] = int'(note_to_load);
          m_rem[v] = int'(duration); m_phase[v] = 0;
        end
    end
    any_after = 0;
    for (int v = 0; v < 3; v++) if (m_valid[v]) any_after = 1;
    m_done = (beat && run && any_before && !any_after) ? 1 : 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model();
    #1;
    chk("final_sample", $signed(final_sample), m_sample);
    chk("sample_ready", sample_ready, m_ready);
    chk("note_done", note_done, m_done);
    if (note_done) begin done_cnt++; done_at = cyc; end
    if (sample_ready && $signed(final_sample) != 0) nz = 1;
    if ($signed(final_sample) > peak) peak = $signed(final_sample);
    if (-$signed(final_sample) > peak) peak = -$signed(final_sample);
    cyc++;
  endtask

  task automatic do_load(input int n, input int d, input int reps);
    note_to_load = 6'(n); duration = 6'(d); load_new_note = 1'b1;
    for (int i = 0; i < reps; i++) cycle();
    load_new_note = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; cycle(); cycle(); reset = 1'b1;
  endtask

  initial begin
    cyc = 0; done_cnt = 0; done_at = -1; nz = 0; peak = 0;
    // Reset, then idle requests with activate low.
    do_reset();
    generate_next_sample = 1'b1; play_enable = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Chord load while paused; third load held for two cycles.
    do_load(36, 4, 1); do_load(32, 4, 1); do_load(26, 4, 2);
    cycle();

    // Play the chord, beat every 5 clocks.
    activate = 1'b1; weight = 2'd2; nz = 0; done_cnt = 0; cyc = 0;
    for (int i = 0; i < 25; i++) begin
      beat = (i % 5 == 4); cycle();
    end
    beat = 1'b0;
    chk("chord_done_count", done_cnt, 1);
    chk("chord_done_cycle", done_at, 19);
    chk("chord_nonzero", nz, 1);

    // Single A440, fundamental only.
    do_reset();
    activate = 1'b0; weight = 2'd0;
    do_load(49, 63, 1);
    activate = 1'b1; peak = 0;
    for (int i = 0; i < 800; i++) cycle();
    chk("a440_peak", peak, 16383);

    // Zero duration into an empty slot, then a fourth note into a full set.
    do_reset();
    do_load(50, 0, 1);
    nz = 0;
    for (int i = 0; i < 4; i++) cycle();
    chk("dur0_silent", nz, 0);
    do_load(10, 5, 1); do_load(20, 5, 1); do_load(30, 5, 1);
    do_load(40, 5, 1); do_load(50, 0, 1);
    for (int i = 0; i < 20; i++) cycle();

    // Pause for three beats mid-chord.
    do_reset();
    weight = 2'd3;
    do_load(40, 3, 1); do_load(45, 3, 1); do_load(52, 3, 1);
    cyc = 0; done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      beat = (i % 4 == 3); play_enable = !(i >= 5 && i <= 16); cycle();
    end
    beat = 1'b0; play_enable = 1'b1;
    chk("pause_done_count", done_cnt, 1);
    chk("pause_done_cycle", done_at, 23);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset                = ($urandom_range(0, 199) != 0);
      load_new_note        = ($urandom_range(0, 5) == 0);
      note_to_load         = 6'($urandom_range(0, 63));
      duration             = 6'($urandom_range(0, 5));
      beat                 = ($urandom_range(0, 6) == 0);
      generate_next_sample = ($urandom_range(0, 3) != 0);
      play_enable          = ($urandom_range(0, 9) != 0);
      activate             = ($urandom_range(0, 9) != 0);
      if (i % 50 == 0) weight = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
